// File: rtl/dioda2_if.sv
// dioda2_if: LED bank drive bundle between the pattern generator and its consumer
interface dioda2_if;
    logic [7:0] oLED;
    modport master (output oLED);
    modport slave (input oLED);
endinterface

// File: rtl/dioda2.sv
// dioda2: prescaled 8-LED light show cycling bounce, fill, drain and blink phases
module dioda2 #(
    parameter int unsigned DIV = 12_500_000
) (
    input logic iCLK,
    input logic iRST,
    dioda2_if.master led
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [1:0] {BOUNCE, FILL, DRAIN, BLINK} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] led_q, led_d;
    logic tick;
    always_comb begin
        tick = cnt_q == CW'(DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        idx_d = idx_q;
        led_d = led_q;
        if (tick) begin
            case (state_q)
                BOUNCE: begin
                    state_d = idx_q == 4'd13 ? FILL : BOUNCE;
                    idx_d = idx_q == 4'd13 ? 4'd0 : idx_q + 4'd1;
                    led_d = idx_q == 4'd13 ? 8'h01 : idx_q < 4'd7 ? led_q << 1 : led_q >> 1;
                end
                FILL: begin
                    state_d = led_q == 8'hFF ? DRAIN : FILL;
                    led_d = led_q == 8'hFF ? 8'h7F : (led_q << 1) | 8'h01;
                end
                DRAIN: begin
                    state_d = led_q == 8'h00 ? BLINK : DRAIN;
                    idx_d = 4'd0;
                    led_d = led_q == 8'h00 ? 8'hAA : led_q >> 1;
                end
                BLINK: begin
                    state_d = idx_q == 4'd7 ? BOUNCE : BLINK;
                    idx_d = idx_q == 4'd7 ? 4'd0 : idx_q + 4'd1;
                    led_d = idx_q == 4'd7 ? 8'h01 : ~led_q;
                end
                default: begin
                    state_d = BOUNCE;
                    idx_d = 4'd0;
                    led_d = 8'h01;
                end
            endcase
        end
    end
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= BOUNCE;
            cnt_q <= '0;
            idx_q <= '0;
            led_q <= 8'h01;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            led_q <= led_d;
        end
    end
    assign led.oLED = led_q;
endmodule

// File: tb/tb_dioda2.sv
// tb_dioda2: four light-show instances (DIV 4,1,2,3) checked against a frame-list model
module tb_dioda2;
    logic clk = 1'b0;
    logic [3:0] rst;
    logic [7:0] led_o [4];
    logic [7:0] seq [38];
    int k [4];
    bit vld [4];
    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        dioda2_if u_if ();
        dioda2 #(.DIV(g == 0 ? 4 : g)) u_dut (
            .iCLK(clk),
            .iRST(rst[g]),
            .led(u_if.master)
        );
        assign led_o[g] = u_if.oLED;
    end

    function automatic int div_of(input int i);
        return i == 0 ? 4 : i;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // after k edges since reset the display shows frame (k / DIV) of the 38-frame loop
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rst[i]) begin
                k[i] = 0;
                vld[i] = 1'b1;
            end else k[i]++;
            if (vld[i])
                chk($sformatf("dut%0d_k%0d", i, k[i]), led_o[i], seq[(k[i] / div_of(i)) % 38]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 14; i++) seq[i] = 8'(1 << (i < 8 ? i : 14 - i));
        for (int i = 0; i < 8; i++) seq[14 + i] = 8'((1 << (i + 1)) - 1);
        for (int i = 0; i < 8; i++) seq[22 + i] = 8'(255 >> (i + 1));
        for (int i = 0; i < 8; i++) seq[30 + i] = i % 2 == 0 ? 8'hAA : 8'h55;
        for (int i = 0; i < 4; i++) begin
            k[i] = 0;
            vld[i] = 1'b0;
        end
        rst = 4'hF;
        repeat (3) step();
        rst = 4'h0;
        chk("rst_dut0", led_o[0], 8'h01);
        repeat (400) step();
        n = 0;
        while (!((k[3] / 3) % 38 == 24 && k[3] % 3 == 2) && n < 300) begin
            step();
            n++;
        end
        chk("mid_rst_reached", 8'(n < 300), 8'h01);
        chk("mid_rst_pre", led_o[3], 8'h1F);
        rst[3] = 1'b1;
        step();
        rst[3] = 1'b0;
        chk("mid_rst_post", led_o[3], 8'h01);
        repeat (200) step();
        repeat (2000) begin
            for (int i = 0; i < 4; i++) rst[i] = $urandom_range(63) == 0;
            step();
        end
        rst = 4'h0;
        repeat (200) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dioda2.md
Name:
dioda2

Overview:
- Free-running 8-LED light-show pattern generator driving the board LED bank from a single system clock (50 MHz nominal, 20 ns period).
- Internal prescaler produces a frame tick every DIV clocks.
- A pattern state machine advances one frame per tick through four fixed phases (bounce, fill, drain, blink), then wraps.
- No other inputs besides clock and reset; top-level leaf block.

Parameters:
- DIV, default 12_500_000, clocks per frame (4 frames/s at 50 MHz); legal range 1..2^31-1; DIV=1 means advance every clock.

Ports:
- iCLK  input  1  system clock; all logic on rising edge.
- iRST  input  1  synchronous, active-high reset.
- oLED  output 8  LED drive, registered; bit i = LED i, 1 = lit.

Behaviour:
- Reset:
  - iRST sampled high at a rising edge sets oLED=8'h01, prescaler=0, state=BOUNCE, frame index=0.
  - Reset has priority over a simultaneous tick.
  - Reset mid-pattern aborts immediately; there is no partial-frame memory.
- Prescaler:
  - Counter width ceil(log2(DIV)), minimum 1 bit.
  - Counts 0..DIV-1 and wraps to 0.
  - tick is asserted in the cycle the counter equals DIV-1.
  - First frame change occurs exactly DIV rising edges after reset release; subsequent changes every DIV clocks.
  - For DIV=1, tick is constantly high.
- Frame update: on tick, oLED loads the next frame value in the same edge; no additional latency stage. oLED holds its value between ticks.
- State machine (index counts frames within a state):
  - BOUNCE, 14 frames: 01,02,04,08,10,20,40,80,40,20,10,08,04,02.
    - One-hot; shifts left until bit7, then right.
    - After frame 02 (index 13), next tick goes to FILL.
  - FILL, 8 frames: 01,03,07,0F,1F,3F,7F,FF.
    - Next value is (oLED<<1)|1.
    - After FF, goes to DRAIN.
  - DRAIN, 8 frames: 7F,3F,1F,0F,07,03,01,00.
    - Logical right shift.
    - After 00, goes to BLINK.
  - BLINK, 8 frames: AA,55,AA,55,AA,55,AA,55.
    - After the last 55, goes to BOUNCE with oLED=01.
- Total cycle is 38 frames (38*DIV clocks); the pattern repeats indefinitely.
- Transition boundaries are exact: the frame that enters a state displays that state's first value on the same tick.
- Unreachable state encodings (if any) recover to BOUNCE/01 on the next tick.
- No X on oLED after the first reset edge. Before any reset, oLED is undefined; benches must apply reset.

Test Plan:
- Reset check (DIV=4): hold iRST high 3 clocks -> oLED==01 and stays 01 for 4 clocks after release; becomes 02 at the 4th edge after release.
- Tick period (DIV=4): measure edges between oLED changes -> exactly 4 clocks each, over a full 38-frame cycle.
- Full sequence (DIV=1): record 38 consecutive values after reset -> 02,04,...,80,40,...,02,01,03,...,FF,7F,...,00,AA,55,...,55,01 (i.e. the frame list shifted by one, ending back at 01); the 39th value is 02.
- Phase boundaries (DIV=2): 80→40 turnaround in BOUNCE; 02→01 entering FILL; FF→7F entering DRAIN; 00→AA entering BLINK; 55→01 wrap.
- Mid-run reset (DIV=3): assert iRST during DRAIN while oLED=1F, coincident with a tick -> next edge oLED=01, sequence restarts from BOUNCE index 0.
- Long run (DIV=1): run 10 full cycles -> sequence is identical each cycle and oLED never X.
